// File: rtl/fifo_pkg.sv
// Shared constants and types for the FIFO read-side stream logic.
package fifo_pkg;

    localparam int FIFO_DATA_WIDTH = 8;
    localparam int SKID_DEPTH      = 3;

    // Pointer / occupancy type: holds 0..SKID_DEPTH.
    typedef logic [1:0] ptr_t;

    // Circular pointer increment, wrapping SKID_DEPTH-1 back to 0.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(SKID_DEPTH - 1)) ? ptr_t'(0) : ptr_t'(p + ptr_t'(1));
    endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Three-entry circular skid buffer: push at wr_ptr, pop from rd_ptr,
// head word always visible from a register so it only moves on clock edges.
module fifo_rd_skid_buf
    import fifo_pkg::*;
#(
    parameter int DW = FIFO_DATA_WIDTH
) (
    input  logic          i_clk,
    input  logic          i_rst,       // asynchronous, active low
    input  logic          i_push,
    input  logic [DW-1:0] i_push_data,
    input  logic          i_pop,
    output logic [DW-1:0] o_head,
    output ptr_t          o_occ
);

    logic [DW-1:0] r_mem [SKID_DEPTH];
    ptr_t          r_wr_ptr;
    ptr_t          r_rd_ptr;
    ptr_t          r_occ;
    logic          w_pop;

    // A pop on an empty buffer is ignored so occ can never underflow.
    assign w_pop = i_pop && (r_occ != ptr_t'(0));

    // Storage, pointers and occupancy; push and pop in one cycle cancel in occ.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < SKID_DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_occ <= r_occ + ptr_t'(i_push) - ptr_t'(w_pop);
        end
    end

    assign o_head = r_mem[r_rd_ptr];
    assign o_occ  = r_occ;

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read-side drain: issues pops against a credit that counts both
// buffered and in-flight words, captures the 1-cycle-late read data into
// the skid buffer, and presents it as a valid/ready stream.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,          // asynchronous, active low
    input  logic                  i_en,
    input  logic                  i_fifo_empty,
    output logic                  o_fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] i_fifo_rd_data,
    output logic                  o_m_valid,
    output logic [DATA_WIDTH-1:0] o_m_data,
    input  logic                  i_m_ready,
    output logic [1:0]            o_occupancy,
    output logic [15:0]           o_xfer_count
);

    logic        r_live;
    logic        r_inflight;
    logic [15:0] r_xfer_count;

    ptr_t        w_occ;
    logic        w_credit_ok;
    logic        w_rd_en;
    logic        w_pop;

    // Credit reserves a slot for the word still in flight, so a push can
    // never land on a full buffer. Only registered state and the FIFO flag
    // feed rd_en; m_ready deliberately stays out of this path.
    assign w_credit_ok = ({1'b0, w_occ} + {2'b00, r_inflight}) < 3'(SKID_DEPTH);
    assign w_rd_en     = r_live && i_en && !i_fifo_empty && w_credit_ok;

    assign o_m_valid   = (w_occ != ptr_t'(0));
    assign w_pop       = o_m_valid && i_m_ready;

    // Hold off reads for the first cycle after reset release.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_live <= 1'b0;
        else        r_live <= 1'b1;
    end

    // Read data arrives one cycle after rd_en; remember that a word is due.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_inflight <= 1'b0;
        else        r_inflight <= w_rd_en;
    end

    // Debug count of accepted stream words, free-running with wrap.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)     r_xfer_count <= '0;
        else if (w_pop) r_xfer_count <= r_xfer_count + 16'd1;
    end

    fifo_rd_skid_buf #(
        .DW          (DATA_WIDTH)
    ) u_skid (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (r_inflight),
        .i_push_data (i_fifo_rd_data),
        .i_pop       (w_pop),
        .o_head      (o_m_data),
        .o_occ       (w_occ)
    );

    assign o_fifo_rd_en = w_rd_en;
    assign o_occupancy  = w_occ;
    assign o_xfer_count = r_xfer_count;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: behavioural FIFO with 1-cycle read latency,
// table of drain scenarios, then hand sequences for multi-cycle corners.
module tb_fifo_rd_stream;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        f_rst_n = 1'b0;
    logic        en = 1'b0;
    logic        m_ready = 1'b0;
    logic        fifo_empty;
    logic [7:0]  fifo_rd_data;
    logic        rd_en;
    logic        m_valid;
    logic [7:0]  m_data;
    logic [1:0]  occ;
    logic [15:0] xfer;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fifo_rd_stream #(.DATA_WIDTH(8)) dut (
        .i_clk          (clk),
        .i_rst          (rst_n),
        .i_en           (en),
        .i_fifo_empty   (fifo_empty),
        .o_fifo_rd_en   (rd_en),
        .i_fifo_rd_data (fifo_rd_data),
        .o_m_valid      (m_valid),
        .o_m_data       (m_data),
        .i_m_ready      (m_ready),
        .o_occupancy    (occ),
        .o_xfer_count   (xfer)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural FIFO: writes queued by the bench land on the next edge,
    // rd_data is registered one cycle after rd_en.
    logic [7:0] q[$];
    logic [7:0] wq[$];
    always @(posedge clk or negedge f_rst_n) begin
        if (!f_rst_n) begin
            q.delete();
            fifo_empty   <= 1'b1;
            fifo_rd_data <= '0;
        end else begin
            if (rd_en) begin
                if (q.size() == 0) chk("fifo_underflow", 32'd1, 32'd0);
                else fifo_rd_data <= q.pop_front();
            end
            while (wq.size() > 0) q.push_back(wq.pop_front());
            fifo_empty <= (q.size() == 0);
        end
    end

    // Consumer/monitor: records pops issued and stream words accepted.
    int         cyc = 0;
    int         pops = 0;
    int         first_pop = -1;
    int         first_valid = -1;
    logic [7:0] got[$];
    int         got_cyc[$];
    always @(posedge clk) begin
        cyc++;
        if (rd_en) begin
            pops++;
            if (first_pop < 0) first_pop = cyc;
        end
        if (m_valid && first_valid < 0) first_valid = cyc;
        if (m_valid && m_ready) begin
            got.push_back(m_data);
            got_cyc.push_back(cyc);
        end
    end

    logic [7:0] words [10];

    typedef struct {
        int          nw;
        bit          rdy;
        int          e_pops;
        logic [1:0]  e_occ;
        logic [7:0]  e_head;
        logic [15:0] e_xfer;
    } vec_t;
    vec_t vt [5];

    task automatic clear_mon();
        got.delete();
        got_cyc.delete();
        pops = 0;
        first_pop = -1;
        first_valid = -1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; f_rst_n = 1'b0;
        en = 1'b1; m_ready = 1'b0;
        wq.delete();
        repeat (2) @(negedge clk);
        clear_mon();
        f_rst_n = 1'b1; rst_n = 1'b1;
    endtask

    task automatic write_words(input int n);
        for (int i = 0; i < n; i++) wq.push_back(words[i]);
    endtask

    task automatic wait_got(input int n, input int budget);
        int k = 0;
        while (got.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("wait_got_timeout", 32'(got.size() >= n), 32'd1);
    endtask

    task automatic chk_order(input string nm, input int n);
        chk({nm, "_count"}, got.size(), n);
        for (int i = 0; i < n && i < got.size(); i++) chk({nm, "_order"}, got[i], words[i]);
    endtask

    initial begin
        words = '{8'h50, 8'hA9, 8'hF0, 8'hEF, 8'h3F, 8'hE9, 8'h01, 8'hFF, 8'h6C, 8'hAC};
        vt[0] = '{nw: 10, rdy: 1'b0, e_pops: 3,  e_occ: 2'd3, e_head: 8'h50, e_xfer: 16'd0};
        vt[1] = '{nw: 2,  rdy: 1'b0, e_pops: 2,  e_occ: 2'd2, e_head: 8'h50, e_xfer: 16'd0};
        vt[2] = '{nw: 1,  rdy: 1'b0, e_pops: 1,  e_occ: 2'd1, e_head: 8'h50, e_xfer: 16'd0};
        vt[3] = '{nw: 10, rdy: 1'b1, e_pops: 10, e_occ: 2'd0, e_head: 8'h00, e_xfer: 16'd10};
        vt[4] = '{nw: 0,  rdy: 1'b1, e_pops: 0,  e_occ: 2'd0, e_head: 8'h00, e_xfer: 16'd0};

        // Reset values while held in reset
        repeat (2) @(negedge clk);
        chk("rst_rd_en", rd_en, 1'b0);
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_data", m_data, 8'h00);
        chk("rst_occ", occ, 2'd0);
        chk("rst_xfer", xfer, 16'd0);

        // Table of drain scenarios
        for (int v = 0; v < 5; v++) begin
            do_reset();
            m_ready = vt[v].rdy;
            write_words(vt[v].nw);
            repeat (20) @(negedge clk);
            chk("tbl_pops", pops, vt[v].e_pops);
            chk("tbl_occ", occ, vt[v].e_occ);
            chk("tbl_valid", m_valid, vt[v].e_occ != 2'd0);
            chk("tbl_xfer", xfer, vt[v].e_xfer);
            if (vt[v].e_occ != 2'd0) chk("tbl_head", m_data, vt[v].e_head);
            if (vt[v].nw > 0) chk("tbl_latency", first_valid - first_pop, 32'd2);
            if (vt[v].rdy) begin
                chk_order("tbl_stream", vt[v].nw);
                for (int i = 1; i < got_cyc.size(); i++)
                    chk("tbl_gapless", got_cyc[i] - got_cyc[0], i);
            end
        end

        // Backpressure then release: rd_en must not react to m_ready in-cycle
        do_reset();
        write_words(10);
        repeat (10) @(negedge clk);
        chk("bp_pops", pops, 3);
        chk("bp_full_rd_en", rd_en, 1'b0);
        m_ready = 1'b1;
        #1 chk("bp_no_comb_path", rd_en, 1'b0);
        @(negedge clk);
        chk("bp_resume_rd_en", rd_en, 1'b1);
        chk("bp_occ_after_pop", occ, 2'd2);
        wait_got(10, 30);
        chk_order("bp", 10);
        for (int i = 1; i < got_cyc.size(); i++) chk("bp_gapless", got_cyc[i] - got_cyc[0], i);
        chk("bp_xfer", xfer, 16'd10);

        // Single word
        do_reset();
        m_ready = 1'b1;
        wq.push_back(8'hEF);
        repeat (10) @(negedge clk);
        chk("single_pops", pops, 1);
        chk("single_latency", first_valid - first_pop, 32'd2);
        chk("single_count", got.size(), 1);
        if (got.size() > 0) chk("single_data", got[0], 8'hEF);
        chk("single_occ", occ, 2'd0);

        // en gating: in-flight word still delivered, no further pops
        do_reset();
        m_ready = 1'b1;
        write_words(5);
        begin
            int k = 0;
            while (pops < 1 && k < 10) begin @(negedge clk); k++; end
        end
        en = 1'b0;
        repeat (8) @(negedge clk);
        chk("en_pops", pops, 1);
        chk("en_inflight_count", got.size(), 1);
        if (got.size() > 0) chk("en_inflight_data", got[0], 8'h50);
        en = 1'b1;
        repeat (12) @(negedge clk);
        chk("en_resume_pops", pops, 5);
        chk_order("en_resume", 5);

        // Asynchronous reset mid-stream with two words buffered
        do_reset();
        write_words(4);
        repeat (10) @(negedge clk);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        chk("mr_pre_occ", occ, 2'd2);
        chk("mr_pre_xfer", xfer, 16'd1);
        #2 rst_n = 1'b0; f_rst_n = 1'b0;
        #1;
        chk("mr_valid", m_valid, 1'b0);
        chk("mr_occ", occ, 2'd0);
        chk("mr_xfer", xfer, 16'd0);
        chk("mr_data", m_data, 8'h00);
        chk("mr_rd_en", rd_en, 1'b0);
        @(negedge clk);
        f_rst_n = 1'b1;
        wq.delete();
        write_words(3);
        repeat (2) @(negedge clk);
        chk("mr_hold_rd_en", rd_en, 1'b0);
        clear_mon();
        rst_n = 1'b1;
        #1 chk("mr_first_cycle_rd_en", rd_en, 1'b0);
        @(negedge clk);
        chk("mr_live_rd_en", rd_en, 1'b1);
        m_ready = 1'b1;
        wait_got(3, 20);
        chk_order("mr_after", 3);

        // Counter wrap through a long gapless stream
        do_reset();
        m_ready = 1'b1;
        begin
            int fed = 0;
            int k = 0;
            logic [15:0] exp_w [3];
            exp_w = '{16'hFFFF, 16'h0000, 16'h0001};
            while (got.size() < 65534 && k < 70000) begin
                while (fed < 65537 && (q.size() + wq.size()) < 4) begin
                    wq.push_back(8'(fed));
                    fed++;
                end
                @(negedge clk);
                k++;
            end
            chk("wrap_reach", 32'(got.size() >= 65534), 32'd1);
            chk("wrap_fffe", xfer, 16'hFFFE);
            for (int j = 0; j < 3; j++) begin
                int b = 0;
                while (got.size() < 65535 + j && b < 5) begin
                    while (fed < 65537 && (q.size() + wq.size()) < 4) begin
                        wq.push_back(8'(fed));
                        fed++;
                    end
                    @(negedge clk);
                    b++;
                end
                chk("wrap_step", xfer, exp_w[j]);
            end
            if (got.size() >= 65537) chk("wrap_last_data", got[65536], 8'h00);
            if (got.size() >= 65534) chk("wrap_mid_data", got[65533], 8'hFD);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
